instruction_fetch_unit: RTL and testbench

- Multicycle fetch stage directly upstream of the immediate generator and decoder.
- Holds the 64-bit PC and issues requests to instruction memory, which has variable latency.
- Latches the returned 32-bit word into an instruction register and presents it downstream with a valid/accept handshake.
- Accepts branch/jump redirects, computed from the generated immediate, and flags misaligned targets.

---
 rtl/instruction_fetch_unit.sv | 105 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Multicycle fetch stage. Holds the PC, requests words from a variable-latency
// instruction memory, latches each returned word into the instruction register
// and offers it downstream on a valid/accept handshake. Redirects load a new PC;
// a misaligned redirect target parks the unit in a sticky fault until reset.
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   imem_req        memory request (FETCH and WAIT), combinational from state
//   imem_addr       fetch address (current pc), combinational
//   imem_ready      memory response valid, sampled only in WAIT
//   imem_rdata      returned instruction word
//   instruction     instruction register, fed to immediate generator/decoder
//   pc_out          address of the word held in instruction
//   instr_valid     instruction/pc_out hold a fetched, unconsumed word
//   instr_accept    downstream consumes the held word
//   redirect        load redirect_target as the new pc
//   redirect_target new pc for a redirect
//   fault           sticky misaligned-redirect flag
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_FETCH | first request cycle at pc; imem_ready ignored
// ST_WAIT  | request held at pc until imem_ready, then capture word
// ST_HOLD  | word presented downstream, fetch stalled until instr_accept
// ST_FAULT | misaligned redirect seen; idle until reset

module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [63:0] pc_out,
    output logic        instr_valid,
    input  logic        instr_accept,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic        fault
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state;
    logic [63:0] pc;

    assign imem_req  = (state == ST_FETCH) || (state == ST_WAIT);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            pc          <= RESET_PC;
            pc_out      <= RESET_PC;
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else if (state != ST_FAULT && redirect) begin
            // Redirect wins over any response or accept in the same cycle;
            // a concurrent response is dropped and the memory re-requested.
            instr_valid <= 1'b0;
            instruction <= NOP_INSTR;
            if (redirect_target[1:0] == 2'b00) begin
                pc    <= redirect_target;
                state <= ST_FETCH;
            end else begin
                fault <= 1'b1;
                state <= ST_FAULT;
            end
        end else begin
            case (state)
                ST_FETCH: state <= ST_WAIT;
                ST_WAIT: begin
                    if (imem_ready) begin
                        instruction <= imem_rdata;
                        pc_out      <= pc;
                        pc          <= pc + 64'd4;
                        instr_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_accept) begin
                        instr_valid <= 1'b0;
                        state       <= ST_FETCH;
                    end
                end
                ST_FAULT: state <= ST_FAULT;
                default:  state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit. Two instances share one stimulus
// stream: one resets to 0, the other to the top word of the address space so
// the pc wrap is exercised. A transaction-level reference model per instance
// predicts every output after every clock edge.

module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [63:0] RPC0 = 64'h0;
    localparam logic [63:0] RPC1 = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_accept;
    logic        redirect;
    logic [63:0] redirect_target;

    logic        req   [2];
    logic [63:0] addr  [2];
    logic [31:0] instr [2];
    logic [63:0] pco   [2];
    logic        vld   [2];
    logic        flt   [2];

    int n_chk  = 0;
    int n_pass = 0;

    // model: where the next word comes from, what is held, fault status
    logic [63:0] m_rpc     [2];
    logic [63:0] m_addr    [2];
    logic [63:0] m_pcout   [2];
    logic [31:0] m_instr   [2];
    bit          m_have    [2];
    bit          m_issued  [2];
    bit          m_faulted [2];

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(RPC0), .NOP_INSTR(NOP)) dut0 (
        .clk(clk), .reset(reset),
        .imem_req(req[0]), .imem_addr(addr[0]),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction(instr[0]), .pc_out(pco[0]), .instr_valid(vld[0]),
        .instr_accept(instr_accept),
        .redirect(redirect), .redirect_target(redirect_target),
        .fault(flt[0])
    );

    instruction_fetch_unit #(.RESET_PC(RPC1), .NOP_INSTR(NOP)) dut1 (
        .clk(clk), .reset(reset),
        .imem_req(req[1]), .imem_addr(addr[1]),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction(instr[1]), .pc_out(pco[1]), .instr_valid(vld[1]),
        .instr_accept(instr_accept),
        .redirect(redirect), .redirect_target(redirect_target),
        .fault(flt[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_addr[i] = m_rpc[i];  m_pcout[i] = m_rpc[i];
                m_instr[i] = NOP;      m_have[i] = 0;
                m_issued[i] = 0;       m_faulted[i] = 0;
            end else if (m_faulted[i]) begin
                // only reset leaves the fault
            end else if (redirect) begin
                m_have[i] = 0;
                m_instr[i] = NOP;
                if (redirect_target[1:0] == 2'b00) begin
                    m_addr[i] = redirect_target;
                    m_issued[i] = 0;
                end else begin
                    m_faulted[i] = 1;
                end
            end else if (m_have[i]) begin
                if (instr_accept) begin
                    m_have[i] = 0;
                    m_issued[i] = 0;
                end
            end else if (!m_issued[i]) begin
                m_issued[i] = 1;
            end else if (imem_ready) begin
                m_instr[i] = imem_rdata;
                m_pcout[i] = m_addr[i];
                m_addr[i]  = m_addr[i] + 64'd4;
                m_have[i]  = 1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            bit exp_req;
            exp_req = !m_faulted[i] && !m_have[i];
            chk($sformatf("u%0d.imem_req", i), {63'd0, req[i]}, {63'd0, exp_req});
            if (exp_req) chk($sformatf("u%0d.imem_addr", i), addr[i], m_addr[i]);
            chk($sformatf("u%0d.instruction", i), {32'd0, instr[i]}, {32'd0, m_instr[i]});
            chk($sformatf("u%0d.pc_out", i), pco[i], m_pcout[i]);
            chk($sformatf("u%0d.instr_valid", i), {63'd0, vld[i]}, {63'd0, m_have[i]});
            chk($sformatf("u%0d.fault", i), {63'd0, flt[i]}, {63'd0, m_faulted[i]});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        reset = 0; imem_ready = 0; imem_rdata = 32'h0;
        instr_accept = 0; redirect = 0; redirect_target = 64'h0;
    endtask

    initial begin
        m_rpc[0] = RPC0;
        m_rpc[1] = RPC1;
        for (int i = 0; i < 2; i++) begin
            m_addr[i] = 0; m_pcout[i] = 0; m_instr[i] = 0;
            m_have[i] = 0; m_issued[i] = 0; m_faulted[i] = 0;
        end
        idle_inputs();

        // reset
        reset = 1;
        cycle();
        cycle();
        reset = 0;

        // first fetch: FETCH then ready in first WAIT cycle
        cycle();
        imem_ready = 1; imem_rdata = 32'h00A00093;
        cycle();
        imem_ready = 0;
        chk("first.valid", {63'd0, vld[0]}, 64'd1);
        chk("first.instr", {32'd0, instr[0]}, 64'h00A00093);
        chk("first.pc_out", pco[0], 64'h0);
        chk("first.next_addr", addr[0], 64'h4);
        chk("wrap.pc_out", pco[1], RPC1);
        chk("wrap.next_addr", addr[1], 64'h0);

        // stall in HOLD
        for (int k = 0; k < 5; k++) cycle();
        chk("hold.req", {63'd0, req[0]}, 64'd0);
        chk("hold.instr", {32'd0, instr[0]}, 64'h00A00093);
        instr_accept = 1;
        cycle();
        instr_accept = 0;
        chk("accept.valid", {63'd0, vld[0]}, 64'd0);
        chk("accept.addr", addr[0], 64'h4);

        // slow memory: 7 cycles of waiting
        cycle();
        for (int k = 0; k < 7; k++) cycle();
        imem_ready = 1; imem_rdata = 32'h00112023;
        cycle();
        imem_ready = 0;
        chk("slow.instr", {32'd0, instr[0]}, 64'h00112023);
        chk("slow.pc_out", pco[0], 64'h4);

        // redirect colliding with a response in WAIT
        instr_accept = 1;
        cycle();
        instr_accept = 0;
        cycle();
        imem_ready = 1; imem_rdata = 32'hDEADBEEF;
        redirect = 1; redirect_target = 64'h100;
        cycle();
        idle_inputs();
        chk("redir.addr", addr[0], 64'h100);
        chk("redir.valid", {63'd0, vld[0]}, 64'd0);
        chk("redir.pc_out", pco[0], 64'h4);
        cycle();

        // misaligned redirect -> sticky fault
        redirect = 1; redirect_target = 64'h102;
        cycle();
        chk("fault.set", {63'd0, flt[0]}, 64'd1);
        chk("fault.req", {63'd0, req[0]}, 64'd0);
        redirect_target = 64'h200; imem_ready = 1;
        cycle();
        cycle();
        idle_inputs();
        chk("fault.sticky", {63'd0, flt[0]}, 64'd1);
        reset = 1;
        cycle();
        reset = 0;
        chk("fault.clear", {63'd0, flt[0]}, 64'd0);
        chk("fault.reset_addr", addr[0], RPC0);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            reset        = ($urandom_range(0, 79) == 0);
            imem_ready   = ($urandom_range(0, 2) == 0);
            imem_rdata   = $urandom;
            instr_accept = $urandom_range(0, 1) == 1;
            redirect     = ($urandom_range(0, 11) == 0);
            redirect_target = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) redirect_target[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
